fifo_ctrl8: RTL and testbench
=============================

Name: fifo_ctrl8

Overview:
Control stage for the 8-entry x 32-bit FIFO. It accepts write/read requests and keeps the write pointer, read pointer and occupancy count. It drives the one-hot write-enable vector into the 8-register storage array and the read address into the output mux/register stage downstream of it. It also reports full/empty and per-request acknowledge/error status.

Parameters:
DEPTH, 8, number of storage entries; must equal the width of the storage enable vector (only 8 supported).
AW, 3, pointer width, log2(DEPTH).
CW, 4, count width, AW+1 (holds 0..8).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset, sampled on rising clk
wr_en  input  1  write request this cycle
rd_en  input  1  read request this cycle
we  output  8  one-hot write enable to storage entries; combinational
rd_addr  output  3  entry index of current FIFO head (registered rd_ptr)
re  output  1  read accepted this cycle; combinational; loads downstream output register
data_count  output  4  registered occupancy 0..8
full  output  1  data_count == 8
empty  output  1  data_count == 0
wr_ack  output  1  registered; previous-cycle write accepted
wr_err  output  1  registered; previous-cycle write rejected (full)
rd_ack  output  1  registered; previous-cycle read accepted
rd_err  output  1  registered; previous-cycle read rejected (empty)

Behaviour:
- Reset (reset_n low at rising edge): wr_ptr=0, rd_ptr=0, data_count=0, wr_ack/wr_err/rd_ack/rd_err=0. Hence empty=1, full=0, rd_addr=0, we=0, re=0.
- Reset overrides any concurrent request. Requests in a reset cycle are dropped with no ack/err. Mid-operation reset discards all contents.
- Accept terms, evaluated on pre-edge registered state:
  - wr_ok = wr_en & ~full
  - rd_ok = rd_en & ~empty
- we = wr_ok ? (8'b1 << wr_ptr) : 8'h00. The storage entry at wr_ptr captures d_in on the same edge, giving zero-cycle write latency. we is never multi-hot.
- re = rd_ok. Downstream captures entry rd_addr on the same edge.
- Pointer updates on each edge:
  - wr_ptr += wr_ok; rd_ptr += rd_ok.
  - Both pointers wrap 7 -> 0 naturally (modulo 8).
- data_count update: +1 on wr_ok only; -1 on rd_ok only; unchanged if both or neither.
- Status registers on each edge:
  - wr_ack <= wr_ok; wr_err <= wr_en & full
  - rd_ack <= rd_ok; rd_err <= rd_en & empty
  - No request -> all four 0 (not sticky).
- Simultaneous wr_en & rd_en:
  - Empty: write accepted, read rejected (rd_err). No bypass; the new word is readable next cycle.
  - Full: read accepted, write rejected (wr_err). Count goes 8 -> 7.
  - Otherwise: both accepted, count unchanged.
- Invariants: data_count never exceeds 8 and never underflows. full and empty are never both 1.
- Internal mode register for debug/coverage, states INIT, NO_OP, WRITE, READ, WR_RD, WR_ERROR, RD_ERROR. It is encoded from the cycle's outcome and is INIT after reset. It has no effect on outputs.

Optional Feature:
FIFO_CTRL_ALMOST_EN
- Defined: adds outputs almost_full (data_count >= 7) and almost_empty (data_count <= 1). Both are derived combinationally from registered data_count. Reset values: almost_full=0, almost_empty=1.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with wr_en=1 -> data_count=0, empty=1, we=0, wr_ack=0 after release.
- Fill: 8 consecutive writes from empty -> we = 01,02,04,...,80 in successive cycles; data_count 1..8; full=1 after 8th edge; 9th write gives wr_err=1, we=00, count stays 8.
- Drain: 8 reads from full -> rd_addr 0..7 then wraps to 0; re=1 each cycle; empty=1 after 8th; 9th read gives rd_err=1, count stays 0.
- Wrap-around: write 5, read 5, write 6 -> we sequence continues 20,40,80,01,02,04; rd_addr=5; data_count=6.
- Simultaneous: both requests at count=0 -> wr_ack=1, rd_err=1, count=1. At count=8 -> rd_ack=1, wr_err=1, count=7. At count=4 -> both acks, count=4, both pointers +1.
- Reset mid-operation at count=5 with wr_en=1,rd_en=1 -> next cycle count=0, pointers 0, no ack/err. With FIFO_CTRL_ALMOST_EN: almost_empty=1, almost_full=0.

Source files
------------

// File: rtl/fifo_ctrl8.sv
// -----------------------------------------------------------------------------
// fifo_ctrl8 - control stage for an 8-entry x 32-bit register FIFO
//
// Purpose:
//   Keeps the write pointer, read pointer and occupancy count for the FIFO.
//   It drives a one-hot write-enable vector into the 8-register storage array
//   and the head index into the downstream output mux/register. It also
//   reports full/empty and registered per-request acknowledge/error status.
//   The storage array and the data path are not part of this block.
//
// Ports:
//   clk          in   1  rising-edge clock
//   reset_n      in   1  synchronous active-low reset, sampled on rising clk
//   wr_en        in   1  write request this cycle
//   rd_en        in   1  read request this cycle
//   we           out  8  one-hot write enable to storage entries (combinational)
//   rd_addr      out  3  index of the current FIFO head (registered rd_ptr)
//   re           out  1  read accepted this cycle (combinational)
//   data_count   out  4  registered occupancy, 0..8
//   full         out  1  data_count == 8
//   empty        out  1  data_count == 0
//   wr_ack       out  1  previous-cycle write accepted
//   wr_err       out  1  previous-cycle write rejected because FIFO was full
//   rd_ack       out  1  previous-cycle read accepted
//   rd_err       out  1  previous-cycle read rejected because FIFO was empty
//
// Optional feature (macro FIFO_CTRL_ALMOST_EN):
//   almost_full  out  1  data_count >= 7
//   almost_empty out  1  data_count <= 1
//   Without the macro these ports and their logic do not exist.
// -----------------------------------------------------------------------------
module fifo_ctrl8 #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [DEPTH-1:0] we,
    output logic [AW-1:0]    rd_addr,
    output logic             re,
    output logic [CW-1:0]    data_count,
    output logic             full,
    output logic             empty,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic             almost_full,
    output logic             almost_empty
`endif
);

    // Cycle-outcome mode, kept for debug visibility and coverage only.
    typedef enum logic [2:0] {
        INIT     = 3'd0,
        NO_OP    = 3'd1,
        WRITE    = 3'd2,
        READ     = 3'd3,
        WR_RD    = 3'd4,
        WR_ERROR = 3'd5,
        RD_ERROR = 3'd6
    } mode_t;

    localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] C_ZERO_CNT = '0;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_wr_ack;
    logic          r_wr_err;
    logic          r_rd_ack;
    logic          r_rd_err;
    mode_t         r_mode;

    // -------------------------------------------------------------------------
    // Combinational terms
    // -------------------------------------------------------------------------
    logic          w_full;
    logic          w_empty;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_wr_rej;
    logic          w_rd_rej;
    logic [AW-1:0] w_wr_ptr_next;
    logic [AW-1:0] w_rd_ptr_next;
    logic [CW-1:0] w_count_next;
    mode_t         w_outcome;
    mode_t         w_mode_next;

    assign w_full  = (r_count == C_FULL_CNT);
    assign w_empty = (r_count == C_ZERO_CNT);

    // Requests presented while reset is asserted are dropped, so the storage
    // array and the downstream output register never see an enable in a
    // reset cycle.
    assign w_wr_ok  = wr_en & ~w_full  & reset_n;
    assign w_rd_ok  = rd_en & ~w_empty & reset_n;
    assign w_wr_rej = wr_en & w_full;
    assign w_rd_rej = rd_en & w_empty;

    // Pointers are exactly AW bits wide, so 7 -> 0 wrap is the natural
    // modulo-8 overflow of the adder.
    assign w_wr_ptr_next = r_wr_ptr + {{(AW-1){1'b0}}, w_wr_ok};
    assign w_rd_ptr_next = r_rd_ptr + {{(AW-1){1'b0}}, w_rd_ok};

    // A simultaneous accepted read and write leaves the count unchanged.
    // Because wr_ok requires ~full and rd_ok requires ~empty, the count can
    // neither exceed DEPTH nor underflow.
    always_comb begin
        w_count_next = r_count;
        unique case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // -------------------------------------------------------------------------
    // One-hot write enable: bit gi is set only when entry gi is the write
    // pointer and the write is accepted, so at most one bit is ever high.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we[gi] = w_wr_ok & (r_wr_ptr == AW'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pointer, count and status registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_wr_ack <= w_wr_ok;
            r_wr_err <= w_wr_rej;
            r_rd_ack <= w_rd_ok;
            r_rd_err <= w_rd_rej;
        end
    end

    // -------------------------------------------------------------------------
    // Debug mode FSM (no effect on outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mode <= INIT;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Rejections take priority in the encoding so that a half-rejected
    // simultaneous request is visible as an error cycle.
    always_comb begin
        w_outcome   = NO_OP;
        w_mode_next = r_mode;
        if (w_wr_ok && w_rd_ok) begin
            w_outcome = WR_RD;
        end else if (w_wr_rej) begin
            w_outcome = WR_ERROR;
        end else if (w_rd_rej) begin
            w_outcome = RD_ERROR;
        end else if (w_wr_ok) begin
            w_outcome = WRITE;
        end else if (w_rd_ok) begin
            w_outcome = READ;
        end else begin
            w_outcome = NO_OP;
        end

        // INIT is held through idle cycles after reset so that it marks
        // "nothing has happened since reset" rather than lasting one cycle.
        unique case (r_mode)
            INIT: begin
                if (wr_en || rd_en) begin
                    w_mode_next = w_outcome;
                end else begin
                    w_mode_next = INIT;
                end
            end
            default: begin
                w_mode_next = w_outcome;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign re         = w_rd_ok;
    assign rd_addr    = r_rd_ptr;
    assign data_count = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign wr_ack     = r_wr_ack;
    assign wr_err     = r_wr_err;
    assign rd_ack     = r_rd_ack;
    assign rd_err     = r_rd_err;

`ifdef FIFO_CTRL_ALMOST_EN
    assign almost_full  = (r_count >= (C_FULL_CNT - CW'(1)));
    assign almost_empty = (r_count <= CW'(1));
`endif

endmodule

// File: tb/tb_fifo_ctrl8.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl8 - directed self-checking bench for fifo_ctrl8
//
// Inputs change just after the falling edge; combinational outputs (we, re)
// are checked before the next rising edge, registered outputs 1 ns after it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_ctrl8;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] we;
    logic [2:0] rd_addr;
    logic       re;
    logic [3:0] data_count;
    logic       full;
    logic       empty;
    logic       wr_ack;
    logic       wr_err;
    logic       rd_ack;
    logic       rd_err;
`ifdef FIFO_CTRL_ALMOST_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    int n_cmp;
    int n_err;

    fifo_ctrl8 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .we         (we),
        .rd_addr    (rd_addr),
        .re         (re),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
`ifdef FIFO_CTRL_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all registered status/occupancy outputs after an edge.
    task automatic chk_state(input string tag, input int cnt, input int addr,
                             input logic wa, input logic we_r, input logic ra, input logic re_r);
        chk({tag, " count"},  32'(data_count), 32'(cnt));
        chk({tag, " rdaddr"}, 32'(rd_addr),    32'(addr));
        chk({tag, " full"},   32'(full),       32'(cnt == 8));
        chk({tag, " empty"},  32'(empty),      32'(cnt == 0));
        chk({tag, " st"}, {28'd0, wr_ack, wr_err, rd_ack, rd_err}, {28'd0, wa, we_r, ra, re_r});
        $display("step %-12s count=%0d rd_addr=%0d acks=%b%b%b%b", tag, data_count, rd_addr,
                 wr_ack, wr_err, rd_ack, rd_err);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b0;

        // ---- Reset held two cycles with a write request pending ----------
        tick();
        chk("rst_we", 32'(we), 32'h00);
        tick();
        chk("rst_we2", 32'(we), 32'h00);
        chk_state("reset", 0, 0, 0, 0, 0, 0);
`ifdef FIFO_CTRL_ALMOST_EN
        chk("rst_afull",  32'(almost_full),  32'd0);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        wr_en   = 1'b0;
        #1;
        chk("idle_we", 32'(we), 32'h00);
        chk("idle_re", 32'(re), 32'd0);
        tick();
        chk_state("post_rst", 0, 0, 0, 0, 0, 0);

        // ---- Fill: 8 writes, we = 01,02,...,80 ----------------------------
        for (int i = 0; i < 8; i++) begin
            drive(1, 0);
            chk("fill_we", 32'(we), 32'(8'h01 << i));
            tick();
            chk_state("fill", i + 1, 0, 1, 0, 0, 0);
        end
`ifdef FIFO_CTRL_ALMOST_EN
        chk("full_afull", 32'(almost_full), 32'd1);
`endif
        drive(1, 0);
        chk("ovf_we", 32'(we), 32'h00);
        tick();
        chk_state("overflow", 8, 0, 0, 1, 0, 0);

        // ---- Drain: 8 reads, rd_addr 0..7 then wrap to 0 ------------------
        for (int i = 0; i < 8; i++) begin
            drive(0, 1);
            chk("drain_re",   32'(re),      32'd1);
            chk("drain_addr", 32'(rd_addr), 32'(i));
            tick();
            chk_state("drain", 7 - i, (i + 1) % 8, 0, 0, 1, 0);
        end
        drive(0, 1);
        chk("udf_re", 32'(re), 32'd0);
        tick();
        chk_state("underflow", 0, 0, 0, 0, 0, 1);

        drive(0, 0);
        tick();
        chk_state("no_req", 0, 0, 0, 0, 0, 0);

        // ---- Wrap-around: write 5, read 5, write 6 ------------------------
        for (int i = 0; i < 5; i++) begin
            drive(1, 0);
            chk("wrap_w1_we", 32'(we), 32'(8'h01 << i));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1);
            chk("wrap_r_addr", 32'(rd_addr), 32'(i));
            tick();
        end
        begin
            logic [7:0] exp_we [6];
            exp_we = '{8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
            for (int i = 0; i < 6; i++) begin
                drive(1, 0);
                chk("wrap_w2_we", 32'(we), 32'(exp_we[i]));
                tick();
            end
        end
        chk_state("wrap", 6, 5, 1, 0, 0, 0);

        // ---- Simultaneous at count=4 (wr_ptr=3, rd_ptr=7 after 2 reads) ---
        drive(0, 1); tick();
        drive(0, 1); tick();
        chk_state("to_4", 4, 7, 0, 0, 1, 0);
        drive(1, 1);
        chk("sim4_we", 32'(we), 32'h08);
        chk("sim4_re", 32'(re), 32'd1);
        tick();
        chk_state("sim_cnt4", 4, 0, 1, 0, 1, 0);

        // ---- Simultaneous at full ----------------------------------------
        for (int i = 0; i < 4; i++) begin
            drive(1, 0);
            chk("tofull_we", 32'(we), 32'(8'h10 << i));
            tick();
        end
        chk_state("to_full", 8, 0, 1, 0, 0, 0);
        drive(1, 1);
        chk("simf_we", 32'(we), 32'h00);
        chk("simf_re", 32'(re), 32'd1);
        tick();
        chk_state("sim_full", 7, 1, 0, 1, 1, 0);

        // ---- Simultaneous at empty (wr_ptr=0 after drain) -----------------
        for (int i = 0; i < 7; i++) begin
            drive(0, 1);
            tick();
        end
        chk_state("to_empty", 0, 0, 0, 0, 1, 0);
        drive(1, 1);
        chk("sime_we", 32'(we), 32'h01);
        chk("sime_re", 32'(re), 32'd0);
        tick();
        chk_state("sim_empty", 1, 0, 1, 0, 0, 1);

        // ---- Mid-operation reset at count=5 -------------------------------
        for (int i = 0; i < 4; i++) begin
            drive(1, 0);
            tick();
        end
        chk_state("to_5", 5, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        #1;
        chk("mrst_we", 32'(we), 32'h00);
        chk("mrst_re", 32'(re), 32'd0);
        tick();
        chk_state("mid_reset", 0, 0, 0, 0, 0, 0);
`ifdef FIFO_CTRL_ALMOST_EN
        chk("mrst_afull",  32'(almost_full),  32'd0);
        chk("mrst_aempty", 32'(almost_empty), 32'd1);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b0;
        #1;
        chk("after_rst_we", 32'(we), 32'h01);
        tick();
        chk_state("after_rst", 1, 0, 1, 0, 0, 0);

        drive(0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
